// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute-stage ALU. Consumes alu_ctrl/cmp_ctrl from the ALU control decoder,
//   returns a registered result and a branch-compare flag. Single-cycle ops
//   retire with latency 1. Shifts iterate SHIFT_STEP bits per cycle.
//
//   Build option: define ALU_EXEC_BARREL_SHIFT_EN to make shifts single-cycle
//   (barrel shifter). In that build the SHIFT state is never entered, busy
//   stays 0 and SHIFT_STEP has no effect.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request valid
//   in_ready   out  unit can accept a request (IDLE only)
//   alu_ctrl   in   ADD=0 SUB=1 XOR=2 OR=3 AND=4 SLL=5 SRL=6 SRA=7, 8..15 NOP
//   cmp_ctrl   in   EQ=0 NE=1 LT=2 GE=3 LTU=4 GEU=5, 6..7 give flag 0
//   op_a       in   operand A (rs1)
//   op_b       in   operand B (rs2 or immediate)
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   result     out  ALU result
//   cmp_flag   out  compare outcome
//   busy       out  shift iteration in progress
//
// State  | meaning
// IDLE   | waiting for a request, in_ready=1
// SHIFT  | iterative shift running, busy=1
// DONE   | result held until out_valid && out_ready
module alu_exec_unit #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [2:0]      cmp_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            cmp_flag,
  output logic            busy
);

  localparam int SH_W = $clog2(XLEN);
  localparam logic [SH_W:0] STEP_C = (SH_W+1)'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [SH_W-1:0] rem_q, rem_d;
  logic [1:0]      kind_q, kind_d;
  logic            sign_q, sign_d;
  logic            cmp_q, cmp_d;

  // kind: 0=SLL 1=SRL 2=SRA. SRA fills with the sign captured at accept,
  // not the current MSB of the working value.
  function automatic logic [XLEN-1:0] shift_by(input logic [1:0] kind,
                                               input logic [XLEN-1:0] val,
                                               input logic [SH_W-1:0] amt,
                                               input logic sign);
    logic [XLEN-1:0] fill;
    fill = ~({XLEN{1'b1}} >> amt);
    case (kind)
      2'd0:    return val << amt;
      2'd1:    return val >> amt;
      default: return (val >> amt) | (sign ? fill : '0);
    endcase
  endfunction

  logic            eq, lt_s, lt_u, cmp_now;
  logic [XLEN-1:0] alu_now;
  logic            is_shift;
  logic [1:0]      kind_in;
  logic [SH_W-1:0] shamt;
  logic [SH_W-1:0] step_amt, rem_left;
  logic [XLEN-1:0] shifted;

  always_comb begin
    eq   = (op_a == op_b);
    lt_s = ($signed(op_a) < $signed(op_b));
    lt_u = (op_a < op_b);
    case (cmp_ctrl)
      3'd0:    cmp_now = eq;
      3'd1:    cmp_now = !eq;
      3'd2:    cmp_now = lt_s;
      3'd3:    cmp_now = !lt_s;
      3'd4:    cmp_now = lt_u;
      3'd5:    cmp_now = !lt_u;
      default: cmp_now = 1'b0;
    endcase
  end

  always_comb begin
    case (alu_ctrl)
      4'd0:    alu_now = op_a + op_b;
      4'd1:    alu_now = op_a - op_b;
      4'd2:    alu_now = op_a ^ op_b;
      4'd3:    alu_now = op_a | op_b;
      4'd4:    alu_now = op_a & op_b;
      // NOP path carries the compare bit so SLT/SLTU fall out for free
      default: alu_now = {{(XLEN-1){1'b0}}, cmp_now};
    endcase
  end

  assign is_shift = (alu_ctrl == 4'd5) || (alu_ctrl == 4'd6) || (alu_ctrl == 4'd7);
  assign kind_in  = (alu_ctrl == 4'd5) ? 2'd0 : (alu_ctrl == 4'd6) ? 2'd1 : 2'd2;
  assign shamt    = op_b[SH_W-1:0];

  // Last iteration shifts only what is left over
  assign step_amt = ({1'b0, rem_q} < STEP_C) ? rem_q : STEP_C[SH_W-1:0];
  assign rem_left = rem_q - step_amt;
  assign shifted  = shift_by(kind_q, work_q, step_amt, sign_q);

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    rem_d    = rem_q;
    kind_d   = kind_q;
    sign_d   = sign_q;
    result_d = result_q;
    cmp_d    = cmp_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cmp_d   = cmp_now;
          state_d = DONE;
          if (is_shift) begin
`ifdef ALU_EXEC_BARREL_SHIFT_EN
            result_d = shift_by(kind_in, op_a, shamt, op_a[XLEN-1]);
`else
            if (shamt == '0) begin
              result_d = op_a;
            end else begin
              work_d  = op_a;
              rem_d   = shamt;
              kind_d  = kind_in;
              sign_d  = op_a[XLEN-1];
              state_d = SHIFT;
            end
`endif
          end else begin
            result_d = alu_now;
          end
        end
      end
      SHIFT: begin
        work_d = shifted;
        rem_d  = rem_left;
        if (rem_left == '0) begin
          result_d = shifted;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      rem_q    <= '0;
      kind_q   <= 2'd0;
      sign_q   <= 1'b0;
      result_q <= '0;
      cmp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      kind_q   <= kind_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      cmp_q    <= cmp_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT);
  assign result    = result_q;
  assign cmp_flag  = cmp_q;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU that consumes the 4-bit alu_ctrl and 3-bit cmp_ctrl codes produced by the ALU control decoder. It performs the operation on two XLEN operands and returns a registered result plus a branch-compare flag. Single-cycle ops complete in one cycle. Shifts run iteratively over multiple cycles. Valid/ready handshakes on both sides let the pipeline stall around multi-cycle ops.

Parameters:
XLEN, 32, operand/result width
SHIFT_STEP, 4, bits shifted per iteration cycle; power of 2, 1..16

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request valid
in_ready  out  1  unit can accept a request
alu_ctrl  in  4  ADD=0 SUB=1 XOR=2 OR=3 AND=4 SLL=5 SRL=6 SRA=7 NOP=8; 9..15 treated as NOP
cmp_ctrl  in  3  EQ=0 NE=1 LT=2 GE=3 LTU=4 GEU=5; 6,7 give flag 0
op_a  in  XLEN  operand A (rs1)
op_b  in  XLEN  operand B (rs2 or immediate)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  XLEN  ALU result
cmp_flag  out  1  compare outcome of cmp_ctrl on op_a/op_b (branch taken / SLT bit)
busy  out  1  shift iteration in progress

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low. One clock domain.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, cmp_flag=0, busy=0.
- States: IDLE, SHIFT, DONE.
- Request is accepted on a rising edge where in_valid && in_ready.
- in_ready is 1 only in IDLE.
- In DONE, in_ready is 0 until the result handshake completes; there is no same-cycle accept-and-retire.
- IDLE to DONE on accept of a non-shift op. result and cmp_flag are registered at that edge, so out_valid is high the next cycle (latency 1).
- IDLE to SHIFT on accept of SLL/SRL/SRA:
  - shamt = op_b[log2(XLEN)-1:0].
  - Working register loads op_a; remaining count loads shamt.
- SHIFT, each cycle:
  - Shift by min(SHIFT_STEP, remaining) and decrement remaining.
  - When remaining reaches 0, go to DONE.
  - shamt=0 goes directly to DONE with result=op_a.
  - Latency = 1 + ceil(shamt/SHIFT_STEP).
- SRA replicates the sign bit captured at accept. SRL and SLL zero-fill.
- busy = (state==SHIFT).
- DONE: out_valid=1. result and cmp_flag stay stable until out_valid && out_ready, then the unit returns to IDLE.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN; no carry out.
  - LT/GE are signed; LTU/GEU are unsigned.
- NOP (including 9..15): result = {XLEN-1 zeros, cmp_flag}. This implements SLT/SLTU, where the decoder emits NOP+LT/LTU.
- cmp_flag is computed and registered for every accepted op, whatever alu_ctrl is.
- Inputs are sampled only at accept. Changes while busy or in DONE are ignored.
- Reset mid-SHIFT or mid-DONE aborts immediately to reset values; the pending result is discarded.

Optional Feature:
- Macro: ALU_EXEC_BARREL_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter with latency 1, the same as other ops. The SHIFT state is never entered, busy is tied 0, and SHIFT_STEP is ignored.
- Undefined: iterative shifting as described under Behaviour.

Test Plan:
- Reset: hold rst_n=0 mid-shift (SLL, op_b=31) -> all outputs at reset values immediately. After release, in_ready=1 and no stale out_valid.
- ADD 0xFFFFFFFF+0x00000001 -> result=0x00000000 one cycle after accept, cmp_flag per cmp_ctrl=EQ equal to 0.
- SUB 5-7 -> result=0xFFFFFFFE.
- SRA op_a=0x80000000, op_b=31, SHIFT_STEP=4:
  - Result=0xFFFFFFFF after 1+8=9 cycles.
  - busy high for 8 cycles; in_ready=0 throughout.
- SLL with op_b=0x20 (shamt=0) -> result=op_a, latency 1.
- SRL 0xF0000000 by 4 -> 0x0F000000.
- NOP+LT op_a=0xFFFFFFFF, op_b=1 -> result=1, cmp_flag=1.
- NOP+LTU same operands -> result=0.
- cmp_ctrl=6 -> cmp_flag=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after a result -> result/out_valid stable, in_ready=0.
  - Raise out_ready -> IDLE next cycle.
  - Back-to-back XOR ops sustain one result per 2 cycles.
